// File: rtl/ex_mem_stage.sv
// Execute stage (forwarding muxes, ALU, branch target) feeding the EX/MEM pipeline register.
// Latency 1 cycle. Stall holds the register and flush loads a bubble. Flush wins over stall.
module ex_mem_stage #(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  valid,
    input  logic [WIDTH-1:0]      inc_pc,
    input  logic [WIDTH-1:0]      read_data_1,
    input  logic [WIDTH-1:0]      read_data_2,
    input  logic [WIDTH-1:0]      sign_extended,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [1:0]            fwd_a_sel,
    input  logic [1:0]            fwd_b_sel,
    input  logic [WIDTH-1:0]      ex_mem_data,
    input  logic [WIDTH-1:0]      mem_wb_data,
    input  logic                  mem_to_reg,
    input  logic                  reg_write,
    input  logic                  branch,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  reg_dest,
    input  logic                  alu_src,
    input  logic [2:0]            alu_op,
    output logic [WIDTH-1:0]      alu_result_reg,
    output logic [WIDTH-1:0]      write_data_reg,
    output logic [WIDTH-1:0]      branch_target_reg,
    output logic                  zero_reg,
    output logic                  pc_src_reg,
    output logic [REG_ADDR_W-1:0] write_reg_reg,
    output logic                  mem_to_reg_reg,
    output logic                  reg_write_reg,
    output logic                  branch_reg,
    output logic                  mem_read_reg,
    output logic                  mem_write_reg,
    output logic                  valid_reg
);

    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_bf;
    logic [WIDTH-1:0] w_op_b;
    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] w_target;
    logic             w_zero;

    always_comb begin
        w_op_a = read_data_1;
        case (fwd_a_sel)
            2'b01:   w_op_a = mem_wb_data;
            2'b10:   w_op_a = ex_mem_data;
            default: w_op_a = read_data_1;
        endcase
    end

    always_comb begin
        w_bf = read_data_2;
        case (fwd_b_sel)
            2'b01:   w_bf = mem_wb_data;
            2'b10:   w_bf = ex_mem_data;
            default: w_bf = read_data_2;
        endcase
    end

    assign w_op_b = alu_src ? sign_extended : w_bf;

    always_comb begin
        w_alu = '0;
        case (alu_op)
            3'b000:  w_alu = w_op_a + w_op_b;
            3'b001:  w_alu = w_op_a - w_op_b;
            3'b010:  w_alu = w_op_a & w_op_b;
            3'b011:  w_alu = w_op_a | w_op_b;
            3'b100:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
            3'b101:  w_alu = ~(w_op_a | w_op_b);
            3'b110:  w_alu = w_op_a ^ w_op_b;
            default: w_alu = w_op_a << w_op_b[4:0];
        endcase
    end

    assign w_zero   = (w_alu == '0);
    assign w_target = inc_pc + (sign_extended << 2);

    // Data fields load even for invalid slots; only control bits are gated by valid.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            alu_result_reg    <= '0;
            write_data_reg    <= '0;
            branch_target_reg <= '0;
            zero_reg          <= 1'b0;
            pc_src_reg        <= 1'b0;
            write_reg_reg     <= '0;
            mem_to_reg_reg    <= 1'b0;
            reg_write_reg     <= 1'b0;
            branch_reg        <= 1'b0;
            mem_read_reg      <= 1'b0;
            mem_write_reg     <= 1'b0;
            valid_reg         <= 1'b0;
        end else if (!stall) begin
            alu_result_reg    <= w_alu;
            write_data_reg    <= w_bf;
            branch_target_reg <= w_target;
            zero_reg          <= w_zero;
            pc_src_reg        <= branch & w_zero & valid;
            write_reg_reg     <= reg_dest ? rd : rt;
            mem_to_reg_reg    <= mem_to_reg & valid;
            reg_write_reg     <= reg_write & valid;
            branch_reg        <= branch & valid;
            mem_read_reg      <= mem_read & valid;
            mem_write_reg     <= mem_write & valid;
            valid_reg         <= valid;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomized and directed bench for ex_mem_stage against a behavioural model of the EX/MEM slot.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, valid;
    logic [31:0] inc_pc, read_data_1, read_data_2, sign_extended, ex_mem_data, mem_wb_data;
    logic [4:0]  rt, rd;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        mem_to_reg, reg_write, branch, mem_read, mem_write, reg_dest, alu_src;
    logic [2:0]  alu_op;
    logic [31:0] alu_result_reg, write_data_reg, branch_target_reg;
    logic        zero_reg, pc_src_reg, mem_to_reg_reg, reg_write_reg, branch_reg;
    logic        mem_read_reg, mem_write_reg, valid_reg;
    logic [4:0]  write_reg_reg;

    // Expected EX/MEM contents
    logic [31:0] e_alu, e_wdata, e_target;
    logic        e_zero, e_pcsrc, e_m2r, e_rw, e_br, e_mr, e_mw, e_valid;
    logic [4:0]  e_wreg;

    int num_checks = 0;
    int num_errors = 0;

    ex_mem_stage #(.WIDTH(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid(valid),
        .inc_pc(inc_pc), .read_data_1(read_data_1), .read_data_2(read_data_2),
        .sign_extended(sign_extended), .rt(rt), .rd(rd),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .ex_mem_data(ex_mem_data), .mem_wb_data(mem_wb_data),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .branch(branch),
        .mem_read(mem_read), .mem_write(mem_write), .reg_dest(reg_dest),
        .alu_src(alu_src), .alu_op(alu_op),
        .alu_result_reg(alu_result_reg), .write_data_reg(write_data_reg),
        .branch_target_reg(branch_target_reg), .zero_reg(zero_reg),
        .pc_src_reg(pc_src_reg), .write_reg_reg(write_reg_reg),
        .mem_to_reg_reg(mem_to_reg_reg), .reg_write_reg(reg_write_reg),
        .branch_reg(branch_reg), .mem_read_reg(mem_read_reg),
        .mem_write_reg(mem_write_reg), .valid_reg(valid_reg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_val);
        if (sel == 2'd1) return mem_wb_data;
        if (sel == 2'd2) return ex_mem_data;
        return reg_val;
    endfunction

    function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: return 32'(longint'(a) + longint'(b));
            3'd1: return 32'(longint'(a) - longint'(b));
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return (sa < sb) ? 32'd1 : 32'd0;
            3'd5: return ~(a | b);
            3'd6: return a ^ b;
            default: return 32'(longint'(a) * (longint'(1) << b[4:0]));
        endcase
    endfunction

    // Advance the model by one edge using the inputs currently applied.
    task automatic model_edge();
        logic [31:0] a, bf, b, r;
        if (reset || flush) begin
            {e_alu, e_wdata, e_target} = '0;
            {e_zero, e_pcsrc, e_m2r, e_rw, e_br, e_mr, e_mw, e_valid} = '0;
            e_wreg = '0;
        end else if (!stall) begin
            a  = pick(fwd_a_sel, read_data_1);
            bf = pick(fwd_b_sel, read_data_2);
            b  = alu_src ? sign_extended : bf;
            r  = alu_model(alu_op, a, b);
            e_alu    = r;
            e_wdata  = bf;
            e_target = 32'(longint'(inc_pc) + 4 * longint'(sign_extended));
            e_zero   = (r == 32'd0);
            e_pcsrc  = valid && branch && (r == 32'd0);
            e_wreg   = reg_dest ? rd : rt;
            e_m2r    = valid && mem_to_reg;
            e_rw     = valid && reg_write;
            e_br     = valid && branch;
            e_mr     = valid && mem_read;
            e_mw     = valid && mem_write;
            e_valid  = valid;
        end
    endtask

    task automatic compare_all();
        check("alu_result", alu_result_reg, e_alu);
        check("write_data", write_data_reg, e_wdata);
        check("branch_target", branch_target_reg, e_target);
        check("zero", 32'(zero_reg), 32'(e_zero));
        check("pc_src", 32'(pc_src_reg), 32'(e_pcsrc));
        check("write_reg", 32'(write_reg_reg), 32'(e_wreg));
        check("mem_to_reg", 32'(mem_to_reg_reg), 32'(e_m2r));
        check("reg_write", 32'(reg_write_reg), 32'(e_rw));
        check("branch", 32'(branch_reg), 32'(e_br));
        check("mem_read", 32'(mem_read_reg), 32'(e_mr));
        check("mem_write", 32'(mem_write_reg), 32'(e_mw));
        check("valid", 32'(valid_reg), 32'(e_valid));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic rand_inputs();
        reset         = ($urandom_range(0, 24) == 0);
        flush         = ($urandom_range(0, 14) == 0);
        stall         = ($urandom_range(0, 4) == 0);
        valid         = ($urandom_range(0, 5) != 0);
        inc_pc        = $urandom;
        read_data_1   = $urandom;
        read_data_2   = $urandom;
        sign_extended = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed(16'($urandom)));
        ex_mem_data   = $urandom;
        mem_wb_data   = $urandom;
        rt            = 5'($urandom);
        rd            = 5'($urandom);
        fwd_a_sel     = 2'($urandom);
        fwd_b_sel     = 2'($urandom);
        {mem_to_reg, reg_write, branch, mem_read, mem_write, reg_dest, alu_src} = 7'($urandom);
        alu_op        = 3'($urandom);
        if ($urandom_range(0, 3) == 0) begin
            fwd_a_sel = 2'd0; fwd_b_sel = 2'd0; alu_src = 1'b0;
            read_data_2 = read_data_1;
        end
    endtask

    task automatic plain(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        rand_inputs();
        reset = 0; flush = 0; stall = 0; valid = 1;
        fwd_a_sel = 2'd0; fwd_b_sel = 2'd0; alu_src = 0;
        read_data_1 = a; read_data_2 = b; alu_op = op;
    endtask

    initial begin
        // Reset held for two cycles with random inputs
        rand_inputs(); reset = 1;
        step();
        rand_inputs(); reset = 1;
        step();
        check("rst_valid", 32'(valid_reg), 32'd0);
        check("rst_alu", alu_result_reg, 32'd0);

        // Subtract into rd
        plain(32'd5, 32'd3, 3'b001);
        reg_write = 1; reg_dest = 1; rd = 5'd7; branch = 0;
        step();
        check("sub_res", alu_result_reg, 32'd2);
        check("sub_wreg", 32'(write_reg_reg), 32'd7);
        check("sub_zero", 32'(zero_reg), 32'd0);

        // Forwarded operands, taken branch with negative offset
        plain(32'h0, 32'h0, 3'b001);
        read_data_1 = 32'h55; read_data_2 = 32'h66;
        fwd_a_sel = 2'b10; ex_mem_data = 32'h10;
        fwd_b_sel = 2'b01; mem_wb_data = 32'h10;
        branch = 1; inc_pc = 32'h100; sign_extended = 32'hFFFF_FFFF;
        step();
        check("br_pcsrc", 32'(pc_src_reg), 32'd1);
        check("br_target", branch_target_reg, 32'h0000_00FC);

        // Load then stall three cycles with changing inputs
        plain(32'h1000, 32'h0, 3'b000);
        alu_src = 1; sign_extended = 32'd8; mem_read = 1;
        step();
        for (int i = 0; i < 3; i++) begin
            rand_inputs(); reset = 0; flush = 0; stall = 1;
            step();
            check("stall_addr", alu_result_reg, 32'h1008);
            check("stall_mr", 32'(mem_read_reg), 32'd1);
        end
        rand_inputs(); reset = 0; flush = 0; stall = 0;
        step();

        // Flush beats stall
        plain(32'h1234, 32'h5678, 3'b000);
        mem_write = 1; step();
        rand_inputs(); reset = 0; flush = 1; stall = 1; mem_write = 1; valid = 1;
        step();
        check("flush_mw", 32'(mem_write_reg), 32'd0);
        check("flush_data", write_data_reg, 32'd0);

        // Signed compare and shift boundaries
        plain(32'hFFFF_FFFF, 32'd1, 3'b100);
        step();
        check("slt_neg", alu_result_reg, 32'd1);
        plain(32'd1, 32'd31, 3'b111);
        step();
        check("sll_31", alu_result_reg, 32'h8000_0000);

        // Reset during stall, then first free edge loads
        plain(32'd9, 32'd9, 3'b110); step();
        rand_inputs(); reset = 1; stall = 1; step();
        plain(32'd4, 32'd6, 3'b011); step();

        for (int n = 0; n < 400; n++) begin
            rand_inputs();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
